card_dealer: RTL and testbench

// - Consumes the prng 8-bit random stream; deals NUM_CARDS distinct cards from a DECK_SIZE deck.
// - Rejection-samples out-of-range bytes (modulo bias) and duplicates, tracked by a used-card bitmap.
// - Sits between prng and hand/display logic; each deal starts with an empty bitmap.

---
 rtl/card_dealer_if.sv | 43 ++++
 rtl/card_dealer.sv | 155 +++++++++++++++
 tb/tb_card_dealer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// rtl/card_dealer_if.sv - card dealer request/sample/hand interface (optional DEALER_REJECT_CNT_EN adds reject_cnt)
interface card_dealer_if #(
  parameter int NUM_CARDS = 7,
  parameter int RND_W     = 8
);
  logic [RND_W-1:0]       rnd;
  logic                   rnd_valid;
  logic                   deal_req;
  logic                   busy;
  logic                   card_valid;
  logic [5:0]             card;
  logic [2:0]             card_idx;
  logic [6*NUM_CARDS-1:0] hand;
  logic                   done;
  logic                   err;
`ifdef DEALER_REJECT_CNT_EN
  logic [15:0]            reject_cnt;

  // Requester side: supplies random samples and deal requests
  modport master (
    output rnd, rnd_valid, deal_req,
    input  busy, card_valid, card, card_idx, hand, done, err, reject_cnt
  );

  // Dealer side
  modport slave (
    input  rnd, rnd_valid, deal_req,
    output busy, card_valid, card, card_idx, hand, done, err, reject_cnt
  );
`else
  // Requester side: supplies random samples and deal requests
  modport master (
    output rnd, rnd_valid, deal_req,
    input  busy, card_valid, card, card_idx, hand, done, err
  );

  // Dealer side
  modport slave (
    input  rnd, rnd_valid, deal_req,
    output busy, card_valid, card, card_idx, hand, done, err
  );
`endif
endinterface

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deals NUM_CARDS distinct cards by rejection sampling a prng stream (DEALER_REJECT_CNT_EN adds reject_cnt)
module card_dealer #(
  parameter int NUM_CARDS = 7,
  parameter int DECK_SIZE = 52,
  parameter int RND_W     = 8,
  parameter int MAX_TRIES = 1024
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  card_dealer_if.slave dif
);

  // Largest multiple of DECK_SIZE representable in RND_W bits; samples at or
  // above it would bias the modulo, so they are thrown away.
  localparam int LIMIT = DECK_SIZE * ((2 ** RND_W) / DECK_SIZE);
  localparam int CW    = 4;
  localparam int TW    = $clog2(MAX_TRIES + 1);
  localparam int HW    = 6 * NUM_CARDS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DECK_SIZE-1:0]  used_q, used_d;
  logic [HW-1:0]         hand_q, hand_d;
  logic [5:0]            card_q, card_d;
  logic [2:0]            card_idx_q, card_idx_d;
  logic [CW-1:0]         count_q, count_d;
  logic [TW-1:0]         tries_q, tries_d;
  logic                  card_valid_q, card_valid_d;
  logic                  err_q, err_d;
`ifdef DEALER_REJECT_CNT_EN
  logic [15:0]           rej_q, rej_d;
`endif

  logic [5:0]            code_c;
  logic                  in_range_c;
  logic                  accept_c;

  // Card code of the current sample and whether it may join the hand
  always_comb begin
    code_c     = 6'(32'(dif.rnd) % 32'(DECK_SIZE));
    in_range_c = 32'(dif.rnd) < 32'(LIMIT);
    accept_c   = in_range_c && !used_q[code_c];
  end

  // Next-state and datapath updates; card_valid is a one-cycle pulse
  always_comb begin
    state_d      = state_q;
    used_d       = used_q;
    hand_d       = hand_q;
    card_d       = card_q;
    card_idx_d   = card_idx_q;
    count_d      = count_q;
    tries_d      = tries_q;
    card_valid_d = 1'b0;
    err_d        = err_q;
`ifdef DEALER_REJECT_CNT_EN
    rej_d        = rej_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (dif.deal_req) begin
          state_d = ST_DRAW;
          used_d  = '0;
          hand_d  = '0;
          count_d = '0;
          tries_d = '0;
          err_d   = 1'b0;
`ifdef DEALER_REJECT_CNT_EN
          rej_d   = '0;
`endif
        end
      end
      ST_DRAW: begin
        if (dif.rnd_valid) begin
          tries_d = tries_q + TW'(1);
          if (accept_c) begin
            used_d[code_c] = 1'b1;
            for (int i = 0; i < NUM_CARDS; i++) begin
              if (count_q == CW'(i)) hand_d[6*i +: 6] = code_c;
            end
            card_d       = code_c;
            card_idx_d   = count_q[2:0];
            card_valid_d = 1'b1;
            count_d      = count_q + CW'(1);
          end
`ifdef DEALER_REJECT_CNT_EN
          else if (rej_q != 16'hFFFF) begin
            rej_d = rej_q + 16'd1;
          end
`endif
          // A completing accept on the final permitted sample is a normal finish
          if (accept_c && (count_q == CW'(NUM_CARDS - 1))) begin
            state_d = ST_DONE;
          end else if (tries_d == TW'(MAX_TRIES)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers; reset discards any partial hand
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      used_q       <= '0;
      hand_q       <= '0;
      card_q       <= '0;
      card_idx_q   <= '0;
      count_q      <= '0;
      tries_q      <= '0;
      card_valid_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef DEALER_REJECT_CNT_EN
      rej_q        <= '0;
`endif
    end else begin
      used_q       <= used_d;
      hand_q       <= hand_d;
      card_q       <= card_d;
      card_idx_q   <= card_idx_d;
      count_q      <= count_d;
      tries_q      <= tries_d;
      card_valid_q <= card_valid_d;
      err_q        <= err_d;
`ifdef DEALER_REJECT_CNT_EN
      rej_q        <= rej_d;
`endif
    end
  end

  assign dif.busy       = (state_q == ST_DRAW);
  assign dif.done       = (state_q == ST_DONE);
  assign dif.err        = err_q;
  assign dif.card_valid = card_valid_q;
  assign dif.card       = card_q;
  assign dif.card_idx   = card_idx_q;
  assign dif.hand       = hand_q;
`ifdef DEALER_REJECT_CNT_EN
  assign dif.reject_cnt = rej_q;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - directed and random deals checked against a queue-based dealer model
module tb_card_dealer;
  localparam int NUM_CARDS = 7;
  localparam int DECK_SIZE = 52;
  localparam int RND_W     = 8;
  localparam int MAX_TRIES = 16;
  localparam int HW        = 6 * NUM_CARDS;
  localparam int LIMIT_M   = ((1 << RND_W) / DECK_SIZE) * DECK_SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  card_dealer_if #(.NUM_CARDS(NUM_CARDS), .RND_W(RND_W)) dif ();

  card_dealer #(
    .NUM_CARDS(NUM_CARDS),
    .DECK_SIZE(DECK_SIZE),
    .RND_W    (RND_W),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .dif   (dif.slave)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 drawing, 2 finished
  int m_phase = 0;
  int m_dealt[$];
  bit m_used[DECK_SIZE];
  int m_tries = 0;
  int m_rej = 0;
  bit m_valid = 1'b0;
  bit m_err = 1'b0;
  int m_card = 0;
  int m_idx = 0;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [HW-1:0] model_hand();
    logic [HW-1:0] h;
    h = '0;
    foreach (m_dealt[i]) h[6*i +: 6] = 6'(m_dealt[i]);
    return h;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_dealt.delete();
    foreach (m_used[i]) m_used[i] = 1'b0;
    m_tries = 0;
    m_rej   = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_card  = 0;
    m_idx   = 0;
  endtask

  task automatic model_step();
    int c;
    int r;
    m_valid = 1'b0;
    if (m_phase != 1) begin
      if (dif.deal_req) begin
        m_dealt.delete();
        foreach (m_used[i]) m_used[i] = 1'b0;
        m_tries = 0;
        m_rej   = 0;
        m_err   = 1'b0;
        m_phase = 1;
      end
    end else if (dif.rnd_valid) begin
      r = int'(dif.rnd);
      c = r % DECK_SIZE;
      m_tries++;
      if (r < LIMIT_M && !m_used[c]) begin
        m_used[c] = 1'b1;
        m_card    = c;
        m_idx     = m_dealt.size();
        m_dealt.push_back(c);
        m_valid   = 1'b1;
        if (m_dealt.size() == NUM_CARDS) m_phase = 2;
      end else if (m_rej < 65535) begin
        m_rej++;
      end
      if (m_phase == 1 && m_tries == MAX_TRIES) begin
        m_phase = 2;
        m_err   = 1'b1;
      end
    end
  endtask

  // Model advances on the same edges as the design
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare every cycle, shortly after the active edge
  initial forever begin
    @(posedge clk);
    #2;
    chk("busy",       64'(dif.busy),       64'(m_phase == 1));
    chk("done",       64'(dif.done),       64'(m_phase == 2));
    chk("err",        64'(dif.err),        64'(m_err));
    chk("card_valid", 64'(dif.card_valid), 64'(m_valid));
    chk("card",       64'(dif.card),       64'(m_card));
    chk("card_idx",   64'(dif.card_idx),   64'(m_idx));
    chk("hand",       64'(dif.hand),       64'(model_hand()));
`ifdef DEALER_REJECT_CNT_EN
    chk("reject_cnt", 64'(dif.reject_cnt), 64'(m_rej));
`endif
  end

  task automatic start_deal();
    dif.deal_req = 1'b1;
    @(negedge clk);
    dif.deal_req = 1'b0;
  endtask

  task automatic feed(input int v, input bit req);
    dif.rnd       = RND_W'(v);
    dif.rnd_valid = 1'b1;
    dif.deal_req  = req;
    @(negedge clk);
    dif.rnd_valid = 1'b0;
    dif.deal_req  = 1'b0;
  endtask

  task automatic idle_cycle(input int v, input bit req);
    dif.rnd       = RND_W'(v);
    dif.rnd_valid = 1'b0;
    dif.deal_req  = req;
    @(negedge clk);
    dif.deal_req  = 1'b0;
  endtask

  task automatic wait_done(input string n);
    int k;
    k = 0;
    while (dif.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(n, 64'(dif.done), 64'd1);
  endtask

  logic [HW-1:0] hand_0_6;
  int seq2[10] = '{5, 5, 57, 109, 10, 11, 12, 13, 14, 15};
  int seq3[10] = '{208, 255, 230, 0, 1, 2, 3, 4, 5, 6};

  initial begin
    hand_0_6      = {6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
    dif.rnd       = '0;
    dif.rnd_valid = 1'b0;
    dif.deal_req  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy",  64'(dif.busy),       64'd0);
    chk("reset_done",  64'(dif.done),       64'd0);
    chk("reset_err",   64'(dif.err),        64'd0);
    chk("reset_valid", 64'(dif.card_valid), 64'd0);
    chk("reset_hand",  64'(dif.hand),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // In-order cards 0..6
    start_deal();
    chk("t1_busy", 64'(dif.busy), 64'd1);
    for (int v = 0; v < 6; v++) feed(v, 1'b0);
    chk("t1_done_early", 64'(dif.done), 64'd0);
    feed(6, 1'b0);
    chk("t1_last_valid", 64'(dif.card_valid), 64'd1);
    chk("t1_last_idx",   64'(dif.card_idx),   64'd6);
    chk("t1_done",       64'(dif.done),       64'd1);
    chk("t1_hand",       64'(dif.hand),       64'(hand_0_6));
    chk("t1_err",        64'(dif.err),        64'd0);

    // Duplicates via equal modulo
    start_deal();
    foreach (seq2[i]) feed(seq2[i], 1'b0);
    wait_done("t2_wait");
    chk("t2_hand", 64'(dif.hand),
        64'({6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10, 6'd5}));
`ifdef DEALER_REJECT_CNT_EN
    chk("t2_rej", 64'(dif.reject_cnt), 64'd3);
`endif

    // Out-of-range samples
    start_deal();
    foreach (seq3[i]) feed(seq3[i], 1'b0);
    wait_done("t3_wait");
    chk("t3_hand", 64'(dif.hand), 64'(hand_0_6));
`ifdef DEALER_REJECT_CNT_EN
    chk("t3_rej", 64'(dif.reject_cnt), 64'd3);
`endif

    // Abort after MAX_TRIES samples
    start_deal();
    for (int i = 0; i < MAX_TRIES - 1; i++) feed(3, 1'b0);
    chk("t4_done_early", 64'(dif.done), 64'd0);
    feed(3, 1'b0);
    chk("t4_done", 64'(dif.done), 64'd1);
    chk("t4_err",  64'(dif.err),  64'd1);
    for (int i = 0; i < 4; i++) feed(7, 1'b0);
    chk("t4_hand", 64'(dif.hand), 64'd3);
`ifdef DEALER_REJECT_CNT_EN
    chk("t4_rej", 64'(dif.reject_cnt), 64'd15);
`endif

    // Reset mid-deal, then re-deal from an empty bitmap
    start_deal();
    for (int v = 0; v < 3; v++) feed(v, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_busy",  64'(dif.busy),       64'd0);
    chk("t5_done",  64'(dif.done),       64'd0);
    chk("t5_valid", 64'(dif.card_valid), 64'd0);
    chk("t5_hand",  64'(dif.hand),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_valid_after", 64'(dif.card_valid), 64'd0);
    start_deal();
    for (int v = 0; v < 7; v++) feed(v, 1'b0);
    wait_done("t5_wait");
    chk("t5_hand_redeal", 64'(dif.hand), 64'(hand_0_6));

    // Gapped rnd_valid with a stray deal_req during DRAW
    start_deal();
    for (int v = 0; v < 7; v++) begin
      feed(v, v == 3);
      idle_cycle(100, v == 5);
      idle_cycle(101, 1'b0);
    end
    wait_done("t6_wait");
    chk("t6_hand", 64'(dif.hand), 64'(hand_0_6));
    chk("t6_err",  64'(dif.err),  64'd0);

    // Random samples, occasional gaps; the model covers aborts too
    for (int d = 0; d < 6; d++) begin
      start_deal();
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(3) == 0) idle_cycle(int'($urandom_range(255)), 1'b0);
        feed(int'($urandom_range(255)), 1'b0);
      end
      wait_done("rand_wait");
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
